sd_block_rx: RTL and testbench
==============================

Name: sd_block_rx

Overview:
Parametrised SD-card DAT-line receive engine for the next-generation reader. It captures one or more consecutive data blocks, as issued by CMD17 or CMD18, in 1-bit or 4-bit bus mode. Each block is checked against its per-lane CRC16 and end bit, and is streamed out as a byte-addressed write interface into sector RAM. It sits between the command controller, which owns sdclk generation and the CMD line, and the sector buffer.

Parameters:
BLOCK_BYTES, 512, bytes per data block; power of two, 16..2048.
TIMEOUT, 1000000, sdclk rising edges allowed between arm/previous block end and the start bit.
AW, $clog2(BLOCK_BYTES), outaddr width (derived, not overridden).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  asynchronous, active-high reset.
sdclk  in  1  SD clock generated in the clk domain; sampled, never used as a clock.
sddat  in  4  SD DAT[3:0]; DAT3 is the nibble MSB.
bus_4bit  in  1  1 = 4-bit mode, 0 = 1-bit mode (DAT0 only); latched at start.
start  in  1  one-cycle arm request; ignored while busy.
blk_count  in  16  number of blocks to receive; 0 is treated as 1; latched at start.
abort  in  1  synchronous cancel.
busy  out  1  high from the cycle after accepted start until done/abort.
done  out  1  one-cycle completion pulse.
crc_err  out  1  sticky CRC or end-bit failure; cleared on accepted start.
timeout_err  out  1  sticky start-bit timeout; cleared on accepted start.
blk_done  out  1  one-cycle pulse per block that passes CRC.
blk_idx  out  16  index of the current block (0-based); holds the failing block on error.
outreq  out  1  one-cycle byte write strobe.
outaddr  out  AW  byte offset within the block.
outbyte  out  8  received byte, MSB first.

Behaviour:
Reset values: every output 0; state IDLE; internal counters and CRC registers 0.

Edge detection:
- sdclk_q registered each clk.
- A sample event is a clk cycle with sdclk_q=0 and sdclk=1.
- All DAT sampling and all counting occur only on sample events.

States: IDLE, WAIT_START, DATA, CRC, ENDBIT, FINISH.

IDLE:
- On start, latch bus_4bit and blk_count.
- Clear crc_err, timeout_err and blk_idx.
- Go to WAIT_START; busy=1 on the next cycle.

WAIT_START:
- Zero all four lane CRCs and the byte/bit counters.
- A start bit is DAT0=0 (1-bit mode) or all four lanes=0 (4-bit mode); on a start bit go to DATA.
- Otherwise increment the timeout counter (width wide enough for TIMEOUT).
- If the count exceeds TIMEOUT: timeout_err=1, go to FINISH.

DATA:
- 1-bit mode: one bit per event; byte complete every 8 events.
- 4-bit mode: one nibble per event, high nibble first; byte complete every 2 events.
- Each active lane updates its own CRC16 every event. Polynomial x^16+x^12+x^5+1, initial value 0, serial MSB-first.
- On byte completion: outreq=1, outbyte=byte, outaddr=byte index, registered on the clk edge after the sample event. outaddr runs 0..BLOCK_BYTES-1 and wraps to 0 for each block.
- After BLOCK_BYTES bytes go to CRC.

CRC:
- 16 events; each active lane shifts its received CRC bit into a compare register.
- Then go to ENDBIT.

ENDBIT:
- One event. Pass = every active lane CRC matches AND every active lane end bit = 1.
- On fail: crc_err=1, go to FINISH.
- On pass: blk_done pulse. If blk_idx+1 == blk_count (effective), go to FINISH. Otherwise increment blk_idx, reset the timeout counter and go to WAIT_START.

FINISH:
- done=1 for one cycle, busy=0, return to IDLE.
- Sticky flags and blk_idx hold until the next accepted start.

Abort:
- abort in any non-IDLE state: next cycle IDLE, busy=0, no done, no further outreq.
- Sticky flags are unchanged.
- abort wins over a simultaneous sample event.

Simultaneous events:
- start together with abort while IDLE: abort wins, start is ignored.
- start in the same cycle as done: ignored; start must be re-issued after busy=0.

Reset mid-transfer: immediate return to reset values; an in-progress byte is discarded.

Lanes 1..3 are ignored entirely in 1-bit mode; their CRC is not checked.

Test Plan:
1. 1-bit, blk_count=1, 512 bytes of 0xFF, CRC 0x7FA1, end bit 1 -> 512 outreq with outaddr 0..511 and outbyte 0xFF; one blk_done; done; crc_err=0.
2. 4-bit, blk_count=3, incrementing pattern (byte n = n mod 256), per-lane CRCs from the bench model -> 1536 outreq, outaddr wrapping 0..511 three times, high nibble taken from the first event; 3 blk_done; blk_idx=2 at done.
3. Same as 2 with block 1 lane 2 CRC bit flipped -> block 0 blk_done only; crc_err=1; blk_idx=1; done; no outreq after block 1's 512 bytes.
4. 1-bit, DAT0 held high, TIMEOUT=100 -> done on the 101st sdclk rising edge; timeout_err=1; zero outreq.
5. abort asserted at byte 200 of block 0 -> busy=0 next clk; no done; no further outreq. A new start then completes normally with flags cleared.
6. rst pulsed mid-DATA, plus blk_count=0 on a later start -> outputs reach 0 asynchronously; the later start receives exactly one block.

Source files
------------

// File: rtl/sd_block_rx.sv
// SD DAT-line receive engine: captures single/multi-block reads in 1- or 4-bit mode,
// verifies per-lane CRC16 and end bit, and streams bytes out as byte-addressed writes.
module sd_block_rx #(
   parameter  int BLOCK_BYTES = 512,
   parameter  int TIMEOUT     = 1000000,
   localparam int AW          = $clog2(BLOCK_BYTES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sdclk,
   input  logic [3:0]    sddat,
   input  logic          bus_4bit,
   input  logic          start,
   input  logic [15:0]   blk_count,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          crc_err,
   output logic          timeout_err,
   output logic          blk_done,
   output logic [15:0]   blk_idx,
   output logic          outreq,
   output logic [AW-1:0] outaddr,
   output logic [7:0]    outbyte
);

   localparam int TW = $clog2(TIMEOUT + 1) + 1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      DATA,
      CRC,
      ENDBIT,
      FINISH
   } state_t;

   state_t        state;
   logic          sdclk_q;
   logic          mode_4;
   logic [15:0]   blk_total;
   logic [TW-1:0] to_cnt;
   logic [AW-1:0] byte_cnt;
   logic [2:0]    bit_cnt;
   logic [3:0]    crc_cnt;
   logic [7:0]    shreg;
   logic [15:0]   crc_calc [4];
   logic [15:0]   crc_rx   [4];

   logic          ev;
   logic          start_bit;
   logic          byte_end;
   logic          blk_ok;
   logic [3:0]    lane_act;
   logic [7:0]    byte_nxt;

   // Serial CRC16-CCITT step (x^16+x^12+x^5+1), MSB first.
   function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   // NOTE: every variable gets a value at the top of this block, so no latch is inferred.
   always_comb begin
      ev        = sdclk & ~sdclk_q;
      lane_act  = mode_4 ? 4'hF : 4'h1;
      start_bit = mode_4 ? (sddat == 4'h0) : ~sddat[0];
      byte_end  = mode_4 ? bit_cnt[0] : (bit_cnt == 3'd7);
      byte_nxt  = mode_4 ? {shreg[3:0], sddat} : {shreg[6:0], sddat[0]};
      blk_ok    = 1'b1;
      for (int i = 0; i < 4; i++)
         if (lane_act[i] && ((crc_calc[i] != crc_rx[i]) || !sddat[i]))
            blk_ok = 1'b0;
   end

   // NOTE: the lane CRC arrays are plain registers, so they take the async reset like everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sdclk_q     <= 1'b0;
         mode_4      <= 1'b0;
         blk_total   <= '0;
         to_cnt      <= '0;
         byte_cnt    <= '0;
         bit_cnt     <= '0;
         crc_cnt     <= '0;
         shreg       <= '0;
         for (int i = 0; i < 4; i++) begin
            crc_calc[i] <= '0;
            crc_rx[i]   <= '0;
         end
         busy        <= 1'b0;
         done        <= 1'b0;
         crc_err     <= 1'b0;
         timeout_err <= 1'b0;
         blk_done    <= 1'b0;
         blk_idx     <= '0;
         outreq      <= 1'b0;
         outaddr     <= '0;
         outbyte     <= '0;
      end else begin
         sdclk_q  <= sdclk;
         done     <= 1'b0;
         blk_done <= 1'b0;
         outreq   <= 1'b0;
         if (abort && state != IDLE) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  // A start coinciding with the done pulse belongs to the old transfer.
                  if (start && !abort && !done) begin
                     mode_4      <= bus_4bit;
                     blk_total   <= (blk_count == 16'd0) ? 16'd1 : blk_count;
                     crc_err     <= 1'b0;
                     timeout_err <= 1'b0;
                     blk_idx     <= '0;
                     to_cnt      <= '0;
                     busy        <= 1'b1;
                     state       <= WAIT_START;
                  end
               end
               WAIT_START: begin
                  byte_cnt <= '0;
                  bit_cnt  <= '0;
                  crc_cnt  <= '0;
                  shreg    <= '0;
                  for (int i = 0; i < 4; i++) begin
                     crc_calc[i] <= '0;
                     crc_rx[i]   <= '0;
                  end
                  if (ev) begin
                     if (start_bit) begin
                        state <= DATA;
                     end else if (to_cnt >= TW'(TIMEOUT)) begin
                        timeout_err <= 1'b1;
                        state       <= FINISH;
                     end else begin
                        to_cnt <= to_cnt + TW'(1);
                     end
                  end
               end
               DATA: begin
                  if (ev) begin
                     shreg <= byte_nxt;
                     for (int i = 0; i < 4; i++)
                        if (lane_act[i])
                           crc_calc[i] <= crc16_step(crc_calc[i], sddat[i]);
                     if (byte_end) begin
                        bit_cnt  <= '0;
                        outreq   <= 1'b1;
                        outbyte  <= byte_nxt;
                        outaddr  <= byte_cnt;
                        byte_cnt <= byte_cnt + AW'(1);
                        if (byte_cnt == AW'(BLOCK_BYTES - 1))
                           state <= CRC;
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               CRC: begin
                  if (ev) begin
                     for (int i = 0; i < 4; i++)
                        if (lane_act[i])
                           crc_rx[i] <= {crc_rx[i][14:0], sddat[i]};
                     crc_cnt <= crc_cnt + 4'd1;
                     if (crc_cnt == 4'd15)
                        state <= ENDBIT;
                  end
               end
               ENDBIT: begin
                  if (ev) begin
                     if (!blk_ok) begin
                        crc_err <= 1'b1;
                        state   <= FINISH;
                     end else begin
                        blk_done <= 1'b1;
                        if (blk_idx + 16'd1 == blk_total) begin
                           state <= FINISH;
                        end else begin
                           blk_idx <= blk_idx + 16'd1;
                           to_cnt  <= '0;
                           state   <= WAIT_START;
                        end
                     end
                  end
               end
               FINISH: begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_block_rx.sv
// Self-checking bench for sd_block_rx: table of block-read scenarios plus
// hand-written timeout, abort and reset sequences.
module tb_sd_block_rx;

   localparam int BB = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic        sdclk;
   logic [3:0]  sddat;
   logic        bus_4bit;
   logic        start;
   logic [15:0] blk_count;
   logic        abort;
   logic        busy;
   logic        done;
   logic        crc_err;
   logic        timeout_err;
   logic        blk_done;
   logic [15:0] blk_idx;
   logic        outreq;
   logic [8:0]  outaddr;
   logic [7:0]  outbyte;

   sd_block_rx #(.BLOCK_BYTES(BB), .TIMEOUT(100)) dut (
      .clk        (clk),
      .rst        (rst),
      .sdclk      (sdclk),
      .sddat      (sddat),
      .bus_4bit   (bus_4bit),
      .start      (start),
      .blk_count  (blk_count),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .crc_err    (crc_err),
      .timeout_err(timeout_err),
      .blk_done   (blk_done),
      .blk_idx    (blk_idx),
      .outreq     (outreq),
      .outaddr    (outaddr),
      .outbyte    (outbyte)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        m4;
      logic [15:0] cnt;
      int          n_send;
      int          pat;
      logic [15:0] known;
      int          fail_blk;
      int          fk;        // 0 none, 1 flip a CRC bit, 2 clear the end bit
      int          fl;
      int          exp_req;
      int          exp_bd;
      logic        exp_crc_err;
      logic [15:0] exp_idx;
   } scn_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   string       cur_scn = "init";
   int          rise_cnt = 0;
   int          n_done, n_bd, done_rise;
   logic [15:0] done_idx;
   logic [8:0]  obs_addr [$];
   logic [7:0]  obs_byte [$];

   always @(negedge clk) begin
      if (outreq) begin
         obs_addr.push_back(outaddr);
         obs_byte.push_back(outbyte);
      end
      if (blk_done) n_bd++;
      if (done) begin
         n_done++;
         done_idx  = blk_idx;
         done_rise = rise_cnt;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got 0x%0h expected 0x%0h", cur_scn, name, act, exp);
      end
   endtask

   task automatic clear_mon();
      obs_addr.delete();
      obs_byte.delete();
      n_done    = 0;
      n_bd      = 0;
      done_rise = 0;
      done_idx  = '0;
      rise_cnt  = 0;
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   function automatic logic [7:0] exp_byte(input int pat, input int n);
      return (pat == 0) ? 8'hFF : 8'(n);
   endfunction

   // One sdclk period: 2 clk low (data changes here), 2 clk high.
   task automatic sd_bit(input logic [3:0] d);
      @(negedge clk);
      sdclk = 1'b0;
      sddat = d;
      @(negedge clk);
      @(negedge clk);
      sdclk = 1'b1;
      rise_cnt++;
      @(negedge clk);
   endtask

   task automatic send_block(input logic m4, input int pat, input logic [15:0] known,
                             input int fk, input int fl);
      logic [15:0] c [4];
      logic [7:0]  b;
      logic [3:0]  d;
      for (int i = 0; i < 4; i++) c[i] = 16'h0000;
      // In 1-bit mode idle lanes 1..3 sit low, which must not look like a start bit.
      repeat (3) sd_bit(m4 ? 4'hF : 4'b0001);
      sd_bit(m4 ? 4'h0 : 4'b1010);
      for (int n = 0; n < BB; n++) begin
         b = exp_byte(pat, n);
         if (m4) begin
            d = b[7:4];
            sd_bit(d);
            for (int i = 0; i < 4; i++) c[i] = crc_step(c[i], d[i]);
            d = b[3:0];
            sd_bit(d);
            for (int i = 0; i < 4; i++) c[i] = crc_step(c[i], d[i]);
         end else begin
            for (int k = 7; k >= 0; k--) begin
               d = {{3{~b[k]}}, b[k]};
               sd_bit(d);
               c[0] = crc_step(c[0], b[k]);
            end
         end
      end
      if (known != 16'h0000) c[0] = known;
      for (int k = 15; k >= 0; k--) begin
         for (int i = 0; i < 4; i++) d[i] = c[i][k];
         if (fk == 1 && k == 3) d[fl] = ~d[fl];
         if (!m4) d[3:1] = 3'b010;
         sd_bit(d);
      end
      d = 4'hF;
      if (fk == 2) d[fl] = 1'b0;
      if (!m4) d[3:1] = 3'b000;
      sd_bit(d);
   endtask

   task automatic pulse_start(input logic m4, input logic [15:0] cnt);
      @(negedge clk);
      bus_4bit  = m4;
      blk_count = cnt;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_scn(input string name, input scn_t s);
      int bad;
      cur_scn = name;
      clear_mon();
      pulse_start(s.m4, s.cnt);
      check("busy_after_start", 32'(busy), 32'd1);
      check("crc_err_cleared", 32'(crc_err), 32'd0);
      check("timeout_err_cleared", 32'(timeout_err), 32'd0);
      for (int b = 0; b < s.n_send; b++)
         send_block(s.m4, s.pat, s.known, (b == s.fail_blk) ? s.fk : 0, s.fl);
      for (int i = 0; i < 200 && n_done == 0; i++) @(negedge clk);
      check("done_pulses", 32'(n_done), 32'd1);
      check("outreq_count", 32'(obs_addr.size()), 32'(s.exp_req));
      bad = 0;
      for (int k = 0; k < obs_addr.size(); k++)
         if (obs_addr[k] !== 9'(k % BB) || obs_byte[k] !== exp_byte(s.pat, k % BB))
            bad++;
      check("stream_bad_bytes", 32'(bad), 32'd0);
      check("blk_done_count", 32'(n_bd), 32'(s.exp_bd));
      check("crc_err", 32'(crc_err), 32'(s.exp_crc_err));
      check("timeout_err", 32'(timeout_err), 32'd0);
      check("blk_idx_at_done", 32'(done_idx), 32'(s.exp_idx));
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   scn_t tbl [4];
   scn_t s;
   logic [7:0] bt;

   initial begin
      //            m4    cnt    send pat known     fblk fk fl req  bd err   idx
      tbl[0] = '{1'b0, 16'd1, 1, 0, 16'h7FA1, -1, 0, 0, 512,  1, 1'b0, 16'd0};
      tbl[1] = '{1'b1, 16'd3, 3, 1, 16'h0000, -1, 0, 0, 1536, 3, 1'b0, 16'd2};
      tbl[2] = '{1'b1, 16'd3, 3, 1, 16'h0000,  1, 1, 2, 1024, 1, 1'b1, 16'd1};
      tbl[3] = '{1'b1, 16'd2, 2, 1, 16'h0000,  0, 2, 3, 512,  0, 1'b1, 16'd0};

      rst = 1'b1; sdclk = 1'b0; sddat = 4'hF; bus_4bit = 1'b0;
      start = 1'b0; blk_count = 16'd0; abort = 1'b0;
      clear_mon();
      #2;
      check("reset_outputs",
            32'({busy, done, crc_err, timeout_err, blk_done, outreq, outaddr, outbyte, blk_idx}),
            32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int t = 0; t < 4; t++) run_scn($sformatf("table%0d", t), tbl[t]);

      // Start-bit timeout: DAT0 never drops.
      cur_scn = "timeout";
      clear_mon();
      pulse_start(1'b0, 16'd1);
      for (int k = 0; k < 200 && n_done == 0; k++) sd_bit(4'b0001);
      repeat (4) @(negedge clk);
      check("done_pulses", 32'(n_done), 32'd1);
      check("done_on_rise", 32'(done_rise), 32'd101);
      check("timeout_err", 32'(timeout_err), 32'd1);
      check("crc_err", 32'(crc_err), 32'd0);
      check("outreq_count", 32'(obs_addr.size()), 32'd0);
      check("busy", 32'(busy), 32'd0);

      // Abort at byte 200 of block 0.
      cur_scn = "abort";
      clear_mon();
      pulse_start(1'b1, 16'd1);
      check("timeout_err_cleared", 32'(timeout_err), 32'd0);
      repeat (2) sd_bit(4'hF);
      sd_bit(4'h0);
      for (int n = 0; n < 200; n++) begin
         bt = 8'(n);
         sd_bit(bt[7:4]);
         sd_bit(bt[3:0]);
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("busy_after_abort", 32'(busy), 32'd0);
      check("outreq_at_abort", 32'(obs_addr.size()), 32'd200);
      for (int n = 200; n < BB; n++) begin
         bt = 8'(n);
         sd_bit(bt[7:4]);
         sd_bit(bt[3:0]);
      end
      repeat (17) sd_bit(4'hF);
      repeat (10) @(negedge clk);
      check("outreq_after_abort", 32'(obs_addr.size()), 32'd200);
      check("no_done", 32'(n_done), 32'd0);
      check("no_blk_done", 32'(n_bd), 32'd0);
      check("crc_err_kept", 32'(crc_err), 32'd0);
      s = '{1'b1, 16'd1, 1, 1, 16'h0000, -1, 0, 0, 512, 1, 1'b0, 16'd0};
      run_scn("restart", s);

      // Reset mid-DATA, then blk_count=0 receives exactly one block.
      cur_scn = "reset";
      clear_mon();
      pulse_start(1'b1, 16'd5);
      sd_bit(4'hF);
      sd_bit(4'h0);
      for (int n = 0; n < 50; n++) begin
         bt = 8'(n);
         sd_bit(bt[7:4]);
         sd_bit(bt[3:0]);
      end
      check("busy_mid_data", 32'(busy), 32'd1);
      check("outbyte_mid_data", 32'(outbyte), 32'h31);
      #1 rst = 1'b1;
      #1;
      check("async_reset_outputs",
            32'({busy, done, crc_err, timeout_err, blk_done, outreq, outaddr, outbyte, blk_idx}),
            32'd0);
      @(negedge clk);
      rst = 1'b0;
      s = '{1'b1, 16'd0, 2, 1, 16'h0000, -1, 0, 0, 512, 1, 1'b0, 16'd0};
      run_scn("count0", s);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
